// File: rtl/venom_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM; a tag pipeline returns each read to its
// requester ROM_LAT+1 cycles after grant. Define VENOM_ARB_FIXED0_EN to give requester 0 absolute priority.
module venom_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 3,
   parameter int ROM_LAT = 1
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [DATA_W-1:0]       rom_q,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    busy
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int CW    = IDX_W + 1;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CW-1:0]    cand_t;

`ifdef VENOM_ARB_FIXED0_EN
   localparam idx_t PTR_RST = idx_t'(1);
`else
   localparam idx_t PTR_RST = '0;
`endif

   idx_t                r_rr_ptr;
   logic [ROM_LAT-1:0]  r_tag_vld;
   idx_t                r_tag_idx [ROM_LAT];

   logic                w_any;
   idx_t                w_idx;
   cand_t               w_cand;
   logic [ADDR_W-1:0]   w_addr;
   logic [N_REQ-1:0]    w_gnt;
   logic [N_REQ-1:0]    w_rsp_onehot;

   // Search upward from r_rr_ptr; the first active request wins
   always_comb begin
      w_any  = 1'b0;
      w_idx  = '0;
      w_cand = '0;
`ifdef VENOM_ARB_FIXED0_EN
      if (req[0]) begin
         w_any = 1'b1;
      end else begin
         for (int i = 0; i < N_REQ - 1; i++) begin
            w_cand = {1'b0, r_rr_ptr} + cand_t'(i);
            if (w_cand >= cand_t'(N_REQ)) w_cand = w_cand - cand_t'(N_REQ - 1);
            if (!w_any && req[w_cand[IDX_W-1:0]]) begin
               w_any = 1'b1;
               w_idx = w_cand[IDX_W-1:0];
            end
         end
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         w_cand = {1'b0, r_rr_ptr} + cand_t'(i);
         if (w_cand >= cand_t'(N_REQ)) w_cand = w_cand - cand_t'(N_REQ);
         if (!w_any && req[w_cand[IDX_W-1:0]]) begin
            w_any = 1'b1;
            w_idx = w_cand[IDX_W-1:0];
         end
      end
`endif
   end

   always_comb begin
      w_gnt        = '0;
      w_addr       = '0;
      w_rsp_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_any && w_idx == idx_t'(k)) begin
            w_gnt[k] = 1'b1;
            w_addr   = req_addr[k*ADDR_W +: ADDR_W];
         end
         if (r_tag_vld[ROM_LAT-1] && r_tag_idx[ROM_LAT-1] == idx_t'(k)) w_rsp_onehot[k] = 1'b1;
      end
   end

   // Grant is withheld while reset is held so no requester believes it was served
   assign gnt  = reset_n ? w_gnt : '0;
   assign busy = |r_tag_vld;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr    <= PTR_RST;
         rom_address <= '0;
         r_tag_vld   <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         for (int i = 0; i < ROM_LAT; i++) r_tag_idx[i] <= '0;
      end else begin
         if (w_any) begin
            rom_address <= w_addr;
`ifdef VENOM_ARB_FIXED0_EN
            if (w_idx != '0)
               r_rr_ptr <= (w_idx == idx_t'(N_REQ - 1)) ? idx_t'(1) : w_idx + 1'b1;
`else
            r_rr_ptr <= (w_idx == idx_t'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
`endif
         end
         r_tag_vld[0] <= w_any;
         r_tag_idx[0] <= w_idx;
         for (int i = 1; i < ROM_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
         end
         // The response register acts as the final tag stage, capturing rom_q as it becomes valid
         rsp_valid <= w_rsp_onehot;
         if (r_tag_vld[ROM_LAT-1]) rsp_data <= rom_q;
      end
   end
endmodule

// File: doc/venom_rom_arbiter.md
# venom_rom_arbiter

Shares one single-port sprite ROM among `N_REQ` requesters, for example the pixel-fetch path, collision probe and projectile renderer, all on `vga_clk`. Each cycle it grants at most one requester with a round-robin policy and drives that requester's address to the ROM. It tracks each in-flight read with a tag pipeline and returns the palette index to the correct requester with fixed latency. It sits between the sprite draw logic and the `*_rom` instance; the palette lookup stays downstream of `rsp_data`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 6: ROM address width.
- `DATA_W`, 3: ROM word (palette index) width.
- `ROM_LAT`, 1: cycles from `rom_address` stable to `rom_q` valid, 1..4.

- `vga_clk` in, 1: sole clock; all state updates on posedge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req` in, `N_REQ`: request per requester.
- `req_addr` in, `N_REQ*ADDR_W`: packed addresses; requester k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `gnt` out, `N_REQ`: one-hot grant, combinational, valid in the request cycle.
- `rom_address` out, `ADDR_W`: registered address to the ROM.
- `rom_q` in, `DATA_W`: ROM read data.
- `rsp_valid` out, `N_REQ`: one-hot, registered, one cycle per completed read.
- `rsp_data` out, `DATA_W`: registered read data, shared by all requesters, qualified by `rsp_valid`.
- `busy` out, 1: high while any read is in flight.

## Operation
- **Request handshake**
  - Requester k holds `req[k]` and its address stable until it sees `gnt[k]` high in the same cycle.
  - A grant consumes the request. The requester may keep `req[k]` high to issue back-to-back reads.
  - Dropping `req` before grant is legal; nothing is issued.
- **Arbitration**
  - Pointer `rr_ptr` (reset 0) names the highest-priority requester.
  - Search starts at `rr_ptr` and runs upward modulo `N_REQ`. The first active `req` wins.
  - On a grant to k, `rr_ptr` becomes (k+1) mod `N_REQ` at the next posedge. With no grant, `rr_ptr` holds.
- **Issue**
  - On the posedge ending the grant cycle, `rom_address` loads the granted address.
  - A tag (valid bit plus requester index) enters a shift register `ROM_LAT+1` stages deep.
  - In cycles with no grant, `rom_address` holds its last value and a tag with valid=0 is shifted in.
- **Return**
  - When a valid tag leaves the last stage, `rom_q` is registered into `rsp_data` and `rsp_valid[tag]` is set for exactly one cycle.
  - `rsp_data` holds its value between responses.
- **busy** is the OR of all tag valid bits.
- **Reset values** (`reset_n` low, asynchronous): `rom_address` 0, `rsp_data` 0, `rsp_valid` 0, all tags invalid, `rr_ptr` 0, `busy` 0. `gnt` is forced 0 while reset is asserted.
- **Reset mid-operation** discards in-flight reads; no `rsp_valid` is produced for them.

## Timing
- Grant cycle T: `gnt[k]`=1.
- T+1: `rom_address` valid.
- T+1+`ROM_LAT`: `rsp_valid[k]`=1 with `rsp_data` equal to ROM[addr].
- Total latency is `ROM_LAT`+1 cycles after the grant cycle.
- Throughput is one read per cycle with no bubbles. Responses return in grant order.
- Simultaneous grant and response to the same requester in one cycle is legal and independent.
- `rr_ptr` wraps from `N_REQ`-1 to 0.
- With `ROM_LAT`=1, the ROM is clocked on the inverted `vga_clk` and samples `rom_address` mid-cycle, so `rom_q` is valid by the posedge ending T+1.

## Configuration
- `VENOM_ARB_FIXED0_EN` defined:
  - Requester 0 (pixel fetch) has absolute priority and is granted whenever `req[0]`=1.
  - Requesters 1..`N_REQ`-1 rotate round-robin among themselves whenever `req[0]`=0.
  - `rr_ptr` ranges over 1..`N_REQ`-1 and resets to 1.
- Undefined: pure round-robin over all requesters as described above.

## Test plan
- Reset, then `req`=0001, addr0=5: `gnt`=0001 at T, `rom_address`=5 at T+1, `rsp_valid`=0001 and `rsp_data`=ROM[5] at T+2 (`ROM_LAT`=1).
- All four requesters held high for 8 cycles: grants run 0,1,2,3,0,1,2,3; `rsp_valid` follows the same order 2 cycles later, one per cycle.
- `req`=1010 with `rr_ptr`=2 after a grant to 1: grant goes to 3, then 1, which confirms wrap-around.
- `reset_n` pulsed low asynchronously mid-cycle with 2 reads in flight: all outputs 0 immediately; no `rsp_valid` after release; the first grant after release goes to requester 0.
- `VENOM_ARB_FIXED0_EN` defined, `req`=1111 held for 6 cycles: `gnt`=0001 every cycle. `req[0]` is then dropped: grants cycle 1,2,3.
- Idle for 3 cycles after a read of addr 9: `rom_address` stays 9, `rsp_data` holds its value, `busy` is 0 once the tag drains.
